// File: rtl/led_serializer_pkg.sv
// Shared constants for the LED serializer: FSM state encoding and frame timing helper.
// The LED_SERIALIZER_OE_EN build option is consumed by led_serializer.sv, not here.
package led_serializer_pkg;

   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
   localparam logic [STATE_W-1:0] ST_SHIFT_LO = 3'd2;
   localparam logic [STATE_W-1:0] ST_SHIFT_HI = 3'd3;
   localparam logic [STATE_W-1:0] ST_LATCH    = 3'd4;
   localparam logic [STATE_W-1:0] ST_GAP      = 3'd5;

   // Cycles from the LOAD cycle through the last GAP cycle, inclusive.
   function automatic int unsigned frame_len(input int unsigned led_width,
                                             input int unsigned clk_div);
      return 1 + 2 * clk_div * led_width + 2 * clk_div;
   endfunction

endpackage

// File: rtl/led_ser_tick.sv
// Phase counter for the serializer FSM: phase_end_o marks the last of CLK_DIV cycles
// spent in the current state; restart_i realigns the count on every state entry.
module led_ser_tick
   import led_serializer_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic restart_i,
   output logic phase_end_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign phase_end_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || phase_end_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_serializer.sv
// Serializes the LED word to a 74HC595-style shift/latch driver, resending on change,
// on force_i, or on a periodic refresh. Define LED_SERIALIZER_OE_EN to add sr_oe_n blanking.
module led_serializer
   import led_serializer_pkg::*;
#(
   parameter int LED_WIDTH      = 16,
   parameter int CLK_DIV        = 8,
   parameter int REFRESH_PERIOD = 40079,
   parameter int MSB_FIRST      = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [LED_WIDTH-1:0] led_i,
   input  logic                 force_i,
   output logic                 sr_clk,
   output logic                 sr_data,
   output logic                 sr_latch,
`ifdef LED_SERIALIZER_OE_EN
   output logic                 sr_oe_n,
`endif
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic [15:0]          frame_count_o
);

   localparam int            BW         = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST   = BW'(LED_WIDTH - 1);
   localparam int            TW         = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam int            REF_LAST_I = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;
   localparam logic [TW-1:0] REF_LAST   = TW'(REF_LAST_I);
   localparam bit            REFRESH_EN = (REFRESH_PERIOD > 0);

   state_t               state_q, state_d;
   logic [LED_WIDTH-1:0] shreg_q, shreg_d;
   logic [LED_WIDTH-1:0] last_sent_q, last_sent_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 pend_q, pend_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [15:0]          count_q, count_d;
   logic                 sr_clk_q, sr_clk_d;
   logic                 sr_data_q, sr_data_d;
   logic                 sr_latch_q, sr_latch_d;
   logic                 busy_q, busy_d;

   logic                 phase_end;
   logic                 restart;
   logic                 refresh_hit;
   logic                 req;

   function automatic logic first_bit(input logic [LED_WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[LED_WIDTH-1] : w[0];
   endfunction

   function automatic logic [LED_WIDTH-1:0] advance(input logic [LED_WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   led_ser_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clock       (clock),
      .reset       (reset),
      .restart_i   (restart),
      .phase_end_o (phase_end)
   );

   assign refresh_hit = REFRESH_EN && (timer_q == REF_LAST);
   assign req         = (led_i != last_sent_q) || force_i || refresh_hit;
   assign restart     = (state_d != state_q);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      last_sent_d = last_sent_q;
      bit_d       = bit_q;
      count_d     = count_q;
      case (state_q)
         ST_IDLE: begin
            if (pend_q || req) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (phase_end) begin
               state_d = ST_SHIFT_HI;
            end
         end
         ST_SHIFT_HI: begin
            if (phase_end) begin
               if (bit_q == '0) begin
                  state_d = ST_LATCH;
               end else begin
                  bit_d   = bit_q - BW'(1);
                  shreg_d = advance(shreg_q);
                  state_d = ST_SHIFT_LO;
               end
            end
         end
         ST_LATCH: begin
            if (phase_end) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               count_d = count_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Snapshot on the edge into LOAD so the first bit is on the pin during LOAD itself.
      if (state_d == ST_LOAD) begin
         shreg_d     = led_i;
         last_sent_d = led_i;
         bit_d       = BIT_LAST;
      end
   end

   always_comb begin
      pend_d = req || (pend_q && (state_q != ST_LOAD));
      timer_d = '0;
      if (REFRESH_EN && (state_d != ST_LOAD) && !refresh_hit) begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_comb begin
      sr_clk_d   = (state_d == ST_SHIFT_HI);
      sr_latch_d = (state_d == ST_LATCH);
      busy_d     = (state_d != ST_IDLE);
      sr_data_d  = 1'b0;
      if ((state_d == ST_LOAD) || (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
         sr_data_d = first_bit(shreg_d);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         last_sent_q <= '0;
         bit_q       <= '0;
         pend_q      <= 1'b1;
         timer_q     <= '0;
         count_q     <= '0;
         sr_clk_q    <= 1'b0;
         sr_data_q   <= 1'b0;
         sr_latch_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         last_sent_q <= last_sent_d;
         bit_q       <= bit_d;
         pend_q      <= pend_d;
         timer_q     <= timer_d;
         count_q     <= count_d;
         sr_clk_q    <= sr_clk_d;
         sr_data_q   <= sr_data_d;
         sr_latch_q  <= sr_latch_d;
         busy_q      <= busy_d;
      end
   end

   assign sr_clk        = sr_clk_q;
   assign sr_data       = sr_data_q;
   assign sr_latch      = sr_latch_q;
   assign busy_o        = busy_q;
   assign frame_done_o  = (state_q == ST_GAP) && phase_end;
   assign frame_count_o = count_q;

`ifdef LED_SERIALIZER_OE_EN
   // Outputs stay blanked until the first complete frame has been latched.
   logic oe_n_q;
   logic oe_n_d;

   always_comb begin
      oe_n_d = oe_n_q;
      if (sr_latch_q && !sr_latch_d) begin
         oe_n_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         oe_n_q <= 1'b1;
      end else begin
         oe_n_q <= oe_n_d;
      end
   end

   assign sr_oe_n = oe_n_q;
`endif

endmodule

// File: tb/tb_led_serializer.sv
// Self-checking bench for led_serializer: a negedge monitor reconstructs each frame from
// the pins and the main sequence compares it with words and timing derived from the stimulus.
module tb_led_serializer;
   import led_serializer_pkg::*;

   localparam int W        = 16;
   localparam int DIV      = 8;
   localparam int REFRESH  = 1000;
   localparam int TIMEOUT  = 3000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  led_i = 16'hA55A;
   logic          force_i = 1'b0;
   logic          sr_clk, sr_data, sr_latch, busy_o, frame_done_o;
   logic [15:0]   frame_count_o;
`ifdef LED_SERIALIZER_OE_EN
   logic          sr_oe_n;
`endif

   led_serializer #(
      .LED_WIDTH      (W),
      .CLK_DIV        (DIV),
      .REFRESH_PERIOD (REFRESH),
      .MSB_FIRST      (1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .led_i         (led_i),
      .force_i       (force_i),
      .sr_clk        (sr_clk),
      .sr_data       (sr_data),
      .sr_latch      (sr_latch),
`ifdef LED_SERIALIZER_OE_EN
      .sr_oe_n       (sr_oe_n),
`endif
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o),
      .frame_count_o (frame_count_o)
   );

   always #12 clock = ~clock;

   typedef struct {
      int          load;
      int          done;
      int          nbits;
      int          latch;
      logic [15:0] word;
   } frame_t;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;
   int          latch_rises = 0;
   int          last_done = 0;
   logic [15:0] exp_count = 16'd0;
   int          frame_len_exp;
   frame_t      cur;
   bit          in_frame = 1'b0;
   logic        busy_p = 1'b0, sclk_p = 1'b0, latch_p = 1'b0;
   int          load_q[$];
   frame_t      done_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc = cyc + 1;

   // Pin-level frame reconstruction; the word is rebuilt from sr_data at sr_clk rising edges.
   always @(negedge clock) begin
      if (reset) begin
         in_frame = 1'b0;
      end else begin
         if (busy_o && !busy_p) begin
            in_frame   = 1'b1;
            cur.load   = cyc;
            cur.word   = 16'd0;
            cur.nbits  = 0;
            cur.latch  = 0;
            load_q.push_back(cyc);
         end
         if (in_frame && sr_clk && !sclk_p) begin
            cur.word  = {cur.word[14:0], sr_data};
            cur.nbits = cur.nbits + 1;
         end
         if (in_frame && sr_latch) cur.latch = cur.latch + 1;
         if (in_frame && frame_done_o) begin
            cur.done = cyc;
            done_q.push_back(cur);
            in_frame = 1'b0;
         end
         if (busy_p && !busy_o) begin
            check("idle_data", {31'd0, sr_data}, 32'd0);
            check("idle_clk", {31'd0, sr_clk}, 32'd0);
         end
      end
      if (sr_latch && !latch_p) latch_rises++;
      busy_p  = busy_o;
      sclk_p  = sr_clk;
      latch_p = sr_latch;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_cycle(input int target);
      int n = 0;
      while (cyc < target && n < TIMEOUT) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_load(output int c);
      int n = 0;
      while (load_q.size() == 0 && n < TIMEOUT) begin
         tick();
         n++;
      end
      if (load_q.size() == 0) begin
         check("load_timeout", 32'd0, 32'd1);
         c = -1;
      end else begin
         c = load_q.pop_front();
      end
   endtask

   task automatic expect_frame(input logic [15:0] w);
      frame_t f;
      int     n = 0;
      while (done_q.size() == 0 && n < TIMEOUT) begin
         tick();
         n++;
      end
      if (done_q.size() == 0) begin
         check("frame_timeout", 32'd0, 32'd1);
      end else begin
         f = done_q.pop_front();
         last_done = f.done;
         exp_count = exp_count + 16'd1;
         $display("frame word=%04h len=%0d bits=%0d latch=%0d count=%0d", f.word,
                  f.done - f.load + 1, f.nbits, f.latch, frame_count_o);
         check("frame_word", {16'd0, f.word}, {16'd0, w});
         check("frame_len", f.done - f.load + 1, frame_len_exp);
         check("frame_bits", f.nbits, W);
         check("latch_len", f.latch, DIV);
         check("frame_count", {16'd0, frame_count_o}, {16'd0, exp_count});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sr_clk"}, {31'd0, sr_clk}, 32'd0);
      check({tag, "_sr_data"}, {31'd0, sr_data}, 32'd0);
      check({tag, "_sr_latch"}, {31'd0, sr_latch}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_done"}, {31'd0, frame_done_o}, 32'd0);
      check({tag, "_count"}, {16'd0, frame_count_o}, 32'd0);
`ifdef LED_SERIALIZER_OE_EN
      check({tag, "_oe_n"}, {31'd0, sr_oe_n}, 32'd1);
`endif
   endtask

   task automatic pulse_force();
      force_i = 1'b1;
      tick();
      force_i = 1'b0;
   endtask

   initial begin
      int          c_load, c_prev, s, k, lr;
      logic [15:0] w, w2;

      frame_len_exp = int'(frame_len(W, DIV));

      // Power-up: reset state, then the first frame starts right after release.
      tick(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      s = cyc;
      wait_load(c_load);
      check("first_load", c_load, s + 1);
      wait_cycle(c_load + 260);
`ifdef LED_SERIALIZER_OE_EN
      check("oe_n_during_latch", {31'd0, sr_oe_n}, 32'd1);
`endif
      expect_frame(16'hA55A);
`ifdef LED_SERIALIZER_OE_EN
      check("oe_n_after_latch", {31'd0, sr_oe_n}, 32'd0);
`endif

      // Constant input: only refresh frames, exactly REFRESH cycles apart.
      repeat (2) begin
         c_prev = c_load;
         wait_load(c_load);
         check("refresh_gap", c_load - c_prev, REFRESH);
         expect_frame(16'hA55A);
      end

      // Word change at cycle 100 of a frame is deferred to exactly one following frame.
      led_i = 16'h0001;
      s = cyc;
      wait_load(c_load);
      check("change_load", c_load, s + 1);
      wait_cycle(c_load + 99);
      led_i = 16'h8000;
      expect_frame(16'h0001);
      wait_load(c_load);
      check("deferred_load", c_load, last_done + 2);
      expect_frame(16'h8000);
      tick(500);
      check("no_extra_after_change", load_q.size(), 0);

      // Two force pulses inside one frame produce a single extra frame.
      s = cyc;
      pulse_force();
      wait_load(c_load);
      check("force_load", c_load, s + 1);
      wait_cycle(c_load + 50);
      pulse_force();
      wait_cycle(c_load + 150);
      pulse_force();
      expect_frame(16'h8000);
      wait_load(c_load);
      check("force_deferred_load", c_load, last_done + 2);
      expect_frame(16'h8000);
      tick(400);
      check("no_extra_after_force", load_q.size(), 0);

      // Random words with a random mid-frame change each.
      for (int it = 0; it < 4; it++) begin
         w = 16'($urandom_range(0, 65535));
         while (w == led_i) w = 16'($urandom_range(0, 65535));
         led_i = w;
         wait_load(c_load);
         k = int'($urandom_range(2, 260));
         wait_cycle(c_load + k);
         w2 = 16'($urandom_range(0, 65535));
         while (w2 == w) w2 = 16'($urandom_range(0, 65535));
         led_i = w2;
         expect_frame(w);
         wait_load(c_load);
         check("rand_deferred_load", c_load, last_done + 2);
         expect_frame(w2);
      end

      // Reset at cycle 50 aborts the frame with no latch; counting restarts from 0.
      pulse_force();
      wait_load(c_load);
      wait_cycle(c_load + 49);
      lr = latch_rises;
      reset = 1'b1;
      tick();
      check_reset_outputs("abort");
      tick(3);
      check("abort_no_latch", latch_rises, lr);
      check("abort_no_done", done_q.size(), 0);
      exp_count = 16'd0;
      reset = 1'b0;
      s = cyc;
      wait_load(c_load);
      check("post_abort_load", c_load, s + 1);
      expect_frame(led_i);
`ifdef LED_SERIALIZER_OE_EN
      check("oe_n_after_relatch", {31'd0, sr_oe_n}, 32'd0);
`endif

      // Counter wrap: preload 0xFFFF, one more frame must read 0x0000.
      force dut.count_q = 16'hFFFF;
      tick(2);
      release dut.count_q;
      tick();
      check("preload_count", {16'd0, frame_count_o}, 32'h0000FFFF);
      exp_count = 16'hFFFF;
      pulse_force();
      wait_load(c_load);
      expect_frame(led_i);
      check("wrapped_count", {16'd0, frame_count_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
